// File: rtl/attention_value_mac_pkg.sv
// Shared definitions for attention_value_mac: FSM state encoding,
// default fixed-point format, accumulator width derivation and
// saturation limit helpers for the signed output format.
package attention_value_mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int DEF_FRAC_WIDTH        = 8;
   localparam int DEF_OUTPUT_DATA_WIDTH = 16;

   // Unsigned DW x signed DW product is 2*DW+1 bits signed; summing
   // DATA_LENGTH of them needs clog2(DATA_LENGTH) guard bits.
   function automatic int acc_width(input int dw, input int dl);
      return 2 * dw + 1 + $clog2(dl);
   endfunction

   // Largest / smallest value representable in a signed ow-bit word.
   function automatic longint sat_max_val(input int ow);
      return (64'sd1 <<< (ow - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min_val(input int ow);
      return -(64'sd1 <<< (ow - 1));
   endfunction

   localparam longint SAT_MAX_DEF = sat_max_val(DEF_OUTPUT_DATA_WIDTH);
   localparam longint SAT_MIN_DEF = sat_min_val(DEF_OUTPUT_DATA_WIDTH);

endpackage

// File: rtl/attention_value_mac_quant.sv
// value_quant_sat: quantizes one accumulator column to the output format.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: i_acc (signed ACC_WIDTH accumulator), o_q (signed saturated result).
module value_quant_sat
   import attention_value_mac_pkg::*;
#(
   parameter int ACC_WIDTH         = 35,
   parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH,
   parameter int FRAC_WIDTH        = DEF_FRAC_WIDTH
) (
   input  logic signed [ACC_WIDTH-1:0]         i_acc,
   output logic signed [OUTPUT_DATA_WIDTH-1:0] o_q
);

   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max_val(OUTPUT_DATA_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min_val(OUTPUT_DATA_WIDTH));
   localparam logic signed [OUTPUT_DATA_WIDTH-1:0] Q_MAX = OUTPUT_DATA_WIDTH'(sat_max_val(OUTPUT_DATA_WIDTH));
   localparam logic signed [OUTPUT_DATA_WIDTH-1:0] Q_MIN = OUTPUT_DATA_WIDTH'(sat_min_val(OUTPUT_DATA_WIDTH));

   logic signed [ACC_WIDTH-1:0] w_shift;

   // Arithmetic shift drops the extra fractional bits, rounding toward -inf.
   assign w_shift = i_acc >>> FRAC_WIDTH;

   always_comb begin
      o_q = w_shift[OUTPUT_DATA_WIDTH-1:0];
      if (w_shift > ACC_MAX) begin
         o_q = Q_MAX;
      end else if (w_shift < ACC_MIN) begin
         o_q = Q_MIN;
      end
   end

endmodule

// File: rtl/attention_value_mac.sv
// attention_value_mac: out[c] = sum_j score[j]*V[j][c], quantized and saturated.
// Latency: output valid one cycle after the last V handshake (DATA_LENGTH+1 edges after score).
// Backpressure: one transaction in flight; result held in DONE until out_ready.
// Ports: score_valid/ready/score (unsigned score row), v_valid/ready/v_row
//        (signed V row), out_valid/ready/out (signed result row), clk, rst.
module attention_value_mac
   import attention_value_mac_pkg::*;
#(
   parameter int DATA_WIDTH        = 16,
   parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH,
   parameter int FRAC_WIDTH        = DEF_FRAC_WIDTH,
   parameter int DATA_LENGTH       = 4,
   parameter int HEAD_DIM          = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  score_valid,
   output logic                                  score_ready,
   input  logic [DATA_WIDTH*DATA_LENGTH-1:0]     score,
   input  logic                                  v_valid,
   output logic                                  v_ready,
   input  logic [DATA_WIDTH*HEAD_DIM-1:0]        v_row,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [OUTPUT_DATA_WIDTH*HEAD_DIM-1:0] out
);

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, DATA_LENGTH);
   localparam int CNT_W     = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
   // Sign-extension bits from the product to the accumulator width
   // (non-zero as long as DATA_LENGTH >= 2).
   localparam int PEXT      = ACC_WIDTH - (2 * DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LENGTH - 1);

   state_t r_state;
   state_t w_state_nxt;

   logic                                  w_score_hs;
   logic                                  w_v_hs;
   logic                                  w_last;
   logic [CNT_W-1:0]                      r_cnt;
   logic [DATA_WIDTH*DATA_LENGTH-1:0]     r_score;
   logic signed [ACC_WIDTH-1:0]           r_acc     [HEAD_DIM];
   logic signed [ACC_WIDTH-1:0]           w_acc_nxt [HEAD_DIM];
   logic [DATA_WIDTH-1:0]                 w_score_sel;
   logic [OUTPUT_DATA_WIDTH*HEAD_DIM-1:0] w_q;
   logic [OUTPUT_DATA_WIDTH*HEAD_DIM-1:0] r_out;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      score_ready = 1'b0;
      v_ready     = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            score_ready = 1'b1;
            if (score_valid) w_state_nxt = ST_ACCUM;
         end
         ST_ACCUM: begin
            v_ready = 1'b1;
            if (v_valid && (r_cnt == CNT_LAST)) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_score_hs = score_valid && score_ready;
   assign w_v_hs     = v_valid && v_ready;
   assign w_last     = (r_cnt == CNT_LAST);

   // ---------------- datapath ----------------
   // Score for the V row currently being consumed.
   always_comb begin
      w_score_sel = '0;
      for (int j = 0; j < DATA_LENGTH; j++) begin
         if (r_cnt == CNT_W'(j)) w_score_sel = r_score[j*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   for (genvar c = 0; c < HEAD_DIM; c++) begin : g_col
      logic signed [DATA_WIDTH:0]     w_sc_ext;
      logic signed [DATA_WIDTH:0]     w_v_ext;
      logic signed [2*DATA_WIDTH+1:0] w_prod;

      // Zero-extend the unsigned score so the multiply is fully signed.
      assign w_sc_ext = {1'b0, w_score_sel};
      assign w_v_ext  = {v_row[DATA_WIDTH*(c+1)-1], v_row[DATA_WIDTH*c +: DATA_WIDTH]};
      assign w_prod   = w_sc_ext * w_v_ext;
      assign w_acc_nxt[c] = r_acc[c] + {{PEXT{w_prod[2*DATA_WIDTH]}}, w_prod[2*DATA_WIDTH:0]};

      value_quant_sat #(
         .ACC_WIDTH         (ACC_WIDTH),
         .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH),
         .FRAC_WIDTH        (FRAC_WIDTH)
      ) u_quant (
         .i_acc (w_acc_nxt[c]),
         .o_q   (w_q[OUTPUT_DATA_WIDTH*c +: OUTPUT_DATA_WIDTH])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_score <= '0;
         r_out   <= '0;
         for (int c = 0; c < HEAD_DIM; c++) r_acc[c] <= '0;
      end else begin
         if (w_score_hs) begin
            r_score <= score;
            r_cnt   <= '0;
            for (int c = 0; c < HEAD_DIM; c++) r_acc[c] <= '0;
         end
         if (w_v_hs) begin
            for (int c = 0; c < HEAD_DIM; c++) r_acc[c] <= w_acc_nxt[c];
            if (w_last) begin
               // Quantize the sum including this final product directly.
               r_out <= w_q;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign out = r_out;

endmodule

// File: doc/attention_value_mac.md
Name: attention_value_mac

Overview:
Downstream neighbour of the softmax stage in the attention datapath. Accepts one softmax score row (DATA_LENGTH unsigned fixed-point scores) and then streams DATA_LENGTH rows of V, one row per handshake. It accumulates out[c] = sum_j score[j]*V[j][c] and emits one quantized, saturated output row (HEAD_DIM elements) per transaction. Valid/ready on all three interfaces.

Parameters:
DATA_WIDTH, 16, width of each score and each V element
OUTPUT_DATA_WIDTH, 16, width of each output element
FRAC_WIDTH, 8, fractional bits of scores, V and output (Q8.8 at defaults)
DATA_LENGTH, 4, scores per row, which is also the number of V rows consumed
HEAD_DIM, 4, elements per V row and per output row

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
score_valid  in  1  score row offered
score_ready  out  1  block accepts a score row
score  in  DATA_WIDTH*DATA_LENGTH  unsigned scores; element j at [DW*(j+1)-1:DW*j]
v_valid  in  1  V row offered
v_ready  out  1  block accepts a V row
v_row  in  DATA_WIDTH*HEAD_DIM  signed two's-complement V elements; column c at [DW*(c+1)-1:DW*c]
out_valid  out  1  result row valid
out_ready  in  1  consumer accepts the result
out  out  OUTPUT_DATA_WIDTH*HEAD_DIM  signed result row, same packing as v_row

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous, active-high. While rst is high: state=IDLE, row counter=0, all accumulators=0, score register=0, out=0, out_valid=0. score_ready and v_ready follow the state (IDLE), so score_ready=1 and v_ready=0.
- Handshake: a transfer occurs on any rising edge where valid && ready. Ready never depends combinationally on valid on the same interface.
- FSM:
  - IDLE: score_ready=1, v_ready=0, out_valid=0. On score handshake: latch score, clear accumulators, cnt=0, go to ACCUM.
  - ACCUM: score_ready=0, v_ready=1. On each V handshake: acc[c] += score[cnt]*v_row[c] for all c, then cnt++. If the handshake occurs with cnt==DATA_LENGTH-1, register out=quant(acc+product) and go to DONE. Cycles with v_valid=0 change nothing.
  - DONE: out_valid=1, score_ready=0, v_ready=0. out is held stable until out_ready=1. On out handshake go to IDLE, and out_valid deasserts the next cycle. out keeps its last value.
- Timing: minimum throughput is one transaction per DATA_LENGTH+2 cycles. If the score handshake is at edge t and V is back-to-back, out_valid rises after edge t+DATA_LENGTH.
- Arithmetic:
  - Product: unsigned DW times signed DW, computed as (DW+1)-bit signed by zero-extending the score, giving a 2*DW+1 bit signed value with 2*FRAC_WIDTH fractional bits.
  - Accumulator: signed, ACC_WIDTH = 2*DW+1+clog2(DATA_LENGTH) bits. Overflow is impossible.
  - quant: arithmetic shift right by FRAC_WIDTH (truncate toward -inf), then saturate to signed OUTPUT_DATA_WIDTH (max 0x7FFF, min 0x8000 at defaults).
- Ignored inputs:
  - v_valid in IDLE or DONE is ignored (v_ready=0).
  - score_valid in ACCUM or DONE is ignored.
  - Input values are sampled only on the handshake edge.
- Reset mid-operation: rst in ACCUM or DONE aborts immediately to the reset values. The partial transaction is discarded and never emitted.
- Zero scores: an all-zero score row yields an all-zero output.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ACCUM, DONE)
  - FRAC_WIDTH default
  - ACC_WIDTH derivation
  - the saturation limit constants
- One natural sub-module, value_quant_sat: combinational shift-and-saturate for one column (ACC_WIDTH in, OUTPUT_DATA_WIDTH out), instantiated HEAD_DIM times in a generate loop.

Test Plan:
1. Basic sum: scores all 0x0100 (1.0); V row j has all columns 0x0100*(j+1); V back-to-back. Required: out all 0x0A00 (10.0), and out_valid is first high after edge t+4.
2. Signed/weighted: score = {0,0,0,0x0200}; V row0 all 0xFF00, other rows all 0x7F00. Required: out all 0xFE00 (-2.0).
3. Saturation: scores all 0x7F00, V all 0x7F00. Required: out all 0x7FFF. Repeat with V all 0x8000. Required: out all 0x8000.
4. Truncation: score = {0,0,0,0x0080}; V row0 columns {0x0001,0xFFFF,0x0002,0xFFFE}, other rows 0. Required: out {0x0000,0xFFFF,0x0001,0xFFFF}.
5. Flow control:
   - Random v_valid gaps: only handshaken rows count.
   - out_ready held low 5 cycles: out stays stable, score_ready=0, and v_valid/score_valid pulses in DONE are ignored.
   - Next transaction starts only after the out handshake.
6. Reset mid-ACCUM: assert rst after 2 V rows. Required: out=0, out_valid=0, score_ready=1, v_ready=0 immediately. A following full case-1 transaction yields 0x0A00.
